traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 181 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Purpose: watches a traffic-light controller's lamps and 7-segment countdown and flags illegal behaviour.
// Latency: 1 clock from a sampleEn cycle to updated outputs.
// Backpressure: none; every sampleEn strobe is evaluated and no sample is ever held off.
//
// Ports:
//   clock, reset              : single clock, synchronous active-high reset
//   sampleEn                  : one-cycle strobe marking a display sample point
//   ledRed/ledGreen/ledYellow : observed lamp outputs
//   led7Seg1, led7Seg0        : observed tens / units segments, {g,f,e,d,c,b,a}, active-low
//   digitValue                : last valid decoded count (tens*10+units)
//   phase                     : 0 IDLE, 1 RED, 2 GREEN, 3 YELLOW
//   sampleValid               : one-cycle pulse when a fully valid sample updated digitValue/phase
//   errFlags                  : sticky {errOrder, errCount, errLamp, errSeg}
//   errPulse                  : one-cycle pulse when the sample raised any error
//   cycleCount                : completed RED->GREEN->YELLOW->RED cycles, wraps at 256
module traffic_light_monitor #(
    parameter int RED_TIME    = 30,
    parameter int GREEN_TIME  = 27,
    parameter int YELLOW_TIME = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sampleEn,
    input  logic       ledRed,
    input  logic       ledGreen,
    input  logic       ledYellow,
    input  logic [6:0] led7Seg1,
    input  logic [6:0] led7Seg0,
    output logic [6:0] digitValue,
    output logic [1:0] phase,
    output logic       sampleValid,
    output logic [3:0] errFlags,
    output logic       errPulse,
    output logic [7:0] cycleCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RED    = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } phase_t;

    localparam int ERR_SEG   = 0;
    localparam int ERR_LAMP  = 1;
    localparam int ERR_COUNT = 2;
    localparam int ERR_ORDER = 3;

    // Registered state. val_q doubles as the "previous value" the next
    // sample is checked against, so it only moves on fully valid samples.
    phase_t      state_q, state_d;
    logic [6:0]  val_q, val_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [3:0]  flags_q, flags_d;
    logic        vld_q, vld_d;
    logic        pulse_q, pulse_d;

    // Combinational view of the current sample.
    logic [4:0]  tens_dec, units_dec;
    logic        seg_ok, lamp_ok;
    phase_t      obs_phase;
    logic [6:0]  obs_val;
    logic [3:0]  err_now;

    // Returns {valid, digit}; anything outside the ten legal glyphs is invalid.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = {1'b1, 4'd0};
            7'b1111001: seg_decode = {1'b1, 4'd1};
            7'b0100100: seg_decode = {1'b1, 4'd2};
            7'b0110000: seg_decode = {1'b1, 4'd3};
            7'b0011001: seg_decode = {1'b1, 4'd4};
            7'b0010010: seg_decode = {1'b1, 4'd5};
            7'b0000010: seg_decode = {1'b1, 4'd6};
            7'b1111000: seg_decode = {1'b1, 4'd7};
            7'b0000000: seg_decode = {1'b1, 4'd8};
            7'b0010000: seg_decode = {1'b1, 4'd9};
            default:    seg_decode = 5'd0;
        endcase
    endfunction

    function automatic phase_t phase_succ(input phase_t p);
        case (p)
            ST_RED:    phase_succ = ST_GREEN;
            ST_GREEN:  phase_succ = ST_YELLOW;
            default:   phase_succ = ST_RED;
        endcase
    endfunction

    function automatic logic [6:0] phase_time(input phase_t p);
        case (p)
            ST_RED:    phase_time = 7'(RED_TIME);
            ST_GREEN:  phase_time = 7'(GREEN_TIME);
            ST_YELLOW: phase_time = 7'(YELLOW_TIME);
            default:   phase_time = 7'd0;
        endcase
    endfunction

    // Sample decode: segments, lamp one-hot check, numeric value.
    always_comb begin
        tens_dec  = seg_decode(led7Seg1);
        units_dec = seg_decode(led7Seg0);
        seg_ok    = tens_dec[4] & units_dec[4];
        lamp_ok   = 1'b0;
        obs_phase = ST_IDLE;
        case ({ledRed, ledGreen, ledYellow})
            3'b100:  begin lamp_ok = 1'b1; obs_phase = ST_RED;    end
            3'b010:  begin lamp_ok = 1'b1; obs_phase = ST_GREEN;  end
            3'b001:  begin lamp_ok = 1'b1; obs_phase = ST_YELLOW; end
            default: begin lamp_ok = 1'b0; obs_phase = ST_IDLE;   end
        endcase
        obs_val = 7'(tens_dec[3:0]) * 7'd10 + 7'(units_dec[3:0]);
    end

    // Next-state / output logic.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cyc_d   = cyc_q;
        flags_d = flags_q;
        vld_d   = 1'b0;
        pulse_d = 1'b0;
        err_now = 4'd0;

        if (sampleEn) begin
            err_now[ERR_SEG]  = ~seg_ok;
            err_now[ERR_LAMP] = ~lamp_ok;

            if (seg_ok && lamp_ok) begin
                vld_d = 1'b1;
                // IDLE just locks onto whatever is shown; no history to check against.
                if (state_q != ST_IDLE) begin
                    if (obs_phase == state_q) begin
                        // Counting down within a phase; a stuck 0 is also a count fault.
                        if ((val_q == 7'd0) || (obs_val != val_q - 7'd1))
                            err_now[ERR_COUNT] = 1'b1;
                    end else begin
                        if (obs_phase != phase_succ(state_q))
                            err_now[ERR_ORDER] = 1'b1;
                        if ((val_q != 7'd0) || (obs_val != phase_time(obs_phase)))
                            err_now[ERR_COUNT] = 1'b1;
                        if ((state_q == ST_YELLOW) && (obs_phase == ST_RED) && !err_now[ERR_COUNT])
                            cyc_d = cyc_q + 8'd1;
                    end
                end
                // Always resync to what was observed so one fault gives one pulse.
                state_d = obs_phase;
                val_d   = obs_val;
            end

            pulse_d = |err_now;
            flags_d = flags_q | err_now;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            val_q   <= 7'd0;
            cyc_q   <= 8'd0;
            flags_q <= 4'd0;
            vld_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cyc_q   <= cyc_d;
            flags_q <= flags_d;
            vld_q   <= vld_d;
            pulse_q <= pulse_d;
        end
    end

    assign digitValue  = val_q;
    assign phase       = state_q;
    assign sampleValid = vld_q;
    assign errFlags    = flags_q;
    assign errPulse    = pulse_q;
    assign cycleCount  = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Purpose: self-checking bench for traffic_light_monitor (vector table, directed sequences, random vs model).
// Latency: outputs checked 1 ns after the rising edge that follows each sample.
// Backpressure: not applicable; the bench strobes sampleEn freely.
module tb_traffic_light_monitor;

    localparam int RT = 30;
    localparam int GT = 27;
    localparam int YT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       sampleEn;
    logic       ledRed, ledGreen, ledYellow;
    logic [6:0] led7Seg1, led7Seg0;
    logic [6:0] digitValue;
    logic [1:0] phase;
    logic       sampleValid;
    logic [3:0] errFlags;
    logic       errPulse;
    logic [7:0] cycleCount;

    traffic_light_monitor #(
        .RED_TIME   (RT),
        .GREEN_TIME (GT),
        .YELLOW_TIME(YT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sampleEn   (sampleEn),
        .ledRed     (ledRed),
        .ledGreen   (ledGreen),
        .ledYellow  (ledYellow),
        .led7Seg1   (led7Seg1),
        .led7Seg0   (led7Seg0),
        .digitValue (digitValue),
        .phase      (phase),
        .sampleValid(sampleValid),
        .errFlags   (errFlags),
        .errPulse   (errPulse),
        .cycleCount (cycleCount)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [10];
    int         times   [4];

    // Reference model state (plain integers, derived from the rules).
    int       m_phase, m_val, m_cyc;
    bit [3:0] m_flags;
    bit       m_valid, m_pulse;

    typedef struct {
        bit         rst;
        bit         r, g, y;
        logic [6:0] s1, s0;
        int         ph, val, vld, pls;
        logic [3:0] flg;
        int         cyc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [6:0] sg(input int d);
        return seg_tab[d];
    endfunction

    task automatic model_reset();
        m_phase = 0; m_val = 0; m_cyc = 0; m_flags = 4'd0; m_valid = 0; m_pulse = 0;
    endtask

    task automatic model_sample(input bit r, input bit g, input bit y,
                                input logic [6:0] s1, input logic [6:0] s0);
        int d1, d0, nl, p, v;
        bit [3:0] e;
        d1 = dec(s1);
        d0 = dec(s0);
        nl = int'(r) + int'(g) + int'(y);
        e  = 4'd0;
        if (d1 < 0 || d0 < 0) e[0] = 1'b1;
        if (nl != 1)          e[1] = 1'b1;
        m_valid = (e == 4'd0);
        if (m_valid) begin
            v = d1 * 10 + d0;
            p = r ? 1 : (g ? 2 : 3);
            if (m_phase != 0) begin
                if (p == m_phase) begin
                    if (v != m_val - 1) e[2] = 1'b1;
                end else begin
                    if (p != (m_phase % 3) + 1)     e[3] = 1'b1;
                    if (m_val != 0 || v != times[p]) e[2] = 1'b1;
                    if (m_phase == 3 && p == 1 && !e[2]) m_cyc = (m_cyc + 1) % 256;
                end
            end
            m_phase = p;
            m_val   = v;
        end
        m_flags = m_flags | e;
        m_pulse = (e != 4'd0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"},       int'(phase),       m_phase);
        chk({tag, ".digitValue"},  int'(digitValue),  m_val);
        chk({tag, ".sampleValid"}, int'(sampleValid), int'(m_valid));
        chk({tag, ".errPulse"},    int'(errPulse),    int'(m_pulse));
        chk({tag, ".errFlags"},    int'(errFlags),    int'(m_flags));
        chk({tag, ".cycleCount"},  int'(cycleCount),  m_cyc);
    endtask

    task automatic drive(input bit rst, input bit r, input bit g, input bit y,
                         input logic [6:0] s1, input logic [6:0] s0);
        @(negedge clock);
        reset = rst; ledRed = r; ledGreen = g; ledYellow = y;
        led7Seg1 = s1; led7Seg0 = s0; sampleEn = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0; sampleEn = 1'b0;
    endtask

    // Reset is applied together with a valid sample to exercise its priority.
    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, sg(1), sg(5));
        model_reset();
        check_model("reset");
    endtask

    task automatic sample_raw(input bit r, input bit g, input bit y,
                              input logic [6:0] s1, input logic [6:0] s0, input string tag);
        model_sample(r, g, y, s1, s0);
        drive(1'b0, r, g, y, s1, s0);
        check_model(tag);
    endtask

    task automatic sample_m(input int p, input int v, input string tag);
        sample_raw(p == 1, p == 2, p == 3, sg(v / 10), sg(v % 10), tag);
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        @(posedge clock);
        #1;
        m_valid = 0; m_pulse = 0;
        check_model("idle");
    endtask

    // Legal traffic: counts down, then moves to the next phase at its full time.
    task automatic legal_cycle_from_red30(input string tag);
        for (int v = RT - 1; v >= 0; v--) sample_m(1, v, tag);
        for (int v = GT; v >= 0; v--)     sample_m(2, v, tag);
        for (int v = YT; v >= 0; v--)     sample_m(3, v, tag);
        sample_m(1, RT, tag);
    endtask

    function automatic vec_t mk(input bit rst, input bit r, input bit g, input bit y,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input int ph, input int val, input int vld, input int pls,
                                input logic [3:0] flg, input int cyc);
        vec_t t;
        t.rst = rst; t.r = r; t.g = g; t.y = y; t.s1 = s1; t.s0 = s0;
        t.ph = ph; t.val = val; t.vld = vld; t.pls = pls; t.flg = flg; t.cyc = cyc;
        return t;
    endfunction

    initial begin
        int gp, gv, k;
        logic [6:0] rs1, rs0;
        logic [2:0] rl;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        times[0] = 0; times[1] = RT; times[2] = GT; times[3] = YT;

        reset = 1'b1; sampleEn = 1'b0;
        ledRed = 1'b0; ledGreen = 1'b0; ledYellow = 1'b0;
        led7Seg1 = 7'h7f; led7Seg0 = 7'h7f;
        model_reset();

        // ---------------- vector table ----------------
        //                 rst r  g  y  tens    units   ph val vld pls flags    cyc
        vecs.push_back(mk(1, 1, 0, 0, sg(1), sg(5),  0, 0,  0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 0, 0, sg(1), sg(5),  1, 15, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 0, 0, sg(1), sg(4),  1, 14, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 0, 0, sg(1), sg(2),  1, 12, 1, 1, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 0, 0, sg(1), sg(1),  1, 11, 1, 0, 4'b0100, 0));
        vecs.push_back(mk(1, 1, 0, 0, sg(1), sg(5),  0, 0,  0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 0, 0, sg(0), sg(0),  1, 0,  1, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 0, 1, sg(0), sg(3),  3, 3,  1, 1, 4'b1000, 0));
        vecs.push_back(mk(0, 0, 0, 1, sg(0), sg(2),  3, 2,  1, 0, 4'b1000, 0));
        vecs.push_back(mk(1, 1, 0, 0, sg(1), sg(5),  0, 0,  0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 1, 0, sg(0), 7'h7f,  0, 0,  0, 1, 4'b0011, 0));
        vecs.push_back(mk(0, 0, 1, 0, sg(0), sg(9),  2, 9,  1, 0, 4'b0011, 0));
        vecs.push_back(mk(1, 1, 0, 0, sg(1), sg(5),  0, 0,  0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, sg(1), sg(0),  2, 10, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 0, 0, sg(1), sg(5),  0, 0,  0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, sg(0), sg(9),  2, 9,  1, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, sg(0), sg(8),  2, 9,  0, 1, 4'b0010, 0));
        vecs.push_back(mk(0, 0, 1, 0, sg(0), sg(8),  2, 8,  1, 0, 4'b0010, 0));
        vecs.push_back(mk(0, 0, 1, 0, 7'h7f, sg(7),  2, 8,  0, 1, 4'b0011, 0));
        vecs.push_back(mk(0, 0, 0, 1, sg(0), sg(2),  3, 2,  1, 1, 4'b0111, 0));
        vecs.push_back(mk(0, 0, 0, 1, sg(0), sg(1),  3, 1,  1, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 0, 0, 1, sg(0), sg(0),  3, 0,  1, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 1, 0, 0, sg(3), sg(0),  1, 30, 1, 0, 4'b0111, 1));
        vecs.push_back(mk(0, 0, 1, 0, sg(2), sg(7),  2, 27, 1, 1, 4'b0111, 1));
        vecs.push_back(mk(0, 1, 0, 0, sg(0), sg(0),  1, 0,  1, 1, 4'b1111, 1));
        vecs.push_back(mk(0, 1, 0, 0, sg(0), sg(0),  1, 0,  1, 1, 4'b1111, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].r, vecs[i].g, vecs[i].y, vecs[i].s1, vecs[i].s0);
            chk($sformatf("vec%0d.phase", i),       int'(phase),       vecs[i].ph);
            chk($sformatf("vec%0d.digitValue", i),  int'(digitValue),  vecs[i].val);
            chk($sformatf("vec%0d.sampleValid", i), int'(sampleValid), vecs[i].vld);
            chk($sformatf("vec%0d.errPulse", i),    int'(errPulse),    vecs[i].pls);
            chk($sformatf("vec%0d.errFlags", i),    int'(errFlags),    int'(vecs[i].flg));
            chk($sformatf("vec%0d.cycleCount", i),  int'(cycleCount),  vecs[i].cyc);
        end

        // ---------------- full legal sequence ----------------
        do_reset();
        sample_m(1, RT, "legal");
        legal_cycle_from_red30("legal");
        chk("legal.final_cycleCount", int'(cycleCount), 1);
        chk("legal.final_errFlags",   int'(errFlags),   0);
        chk("legal.final_phase",      int'(phase),      1);
        idle_cycle();

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        gp = 1; gv = RT;
        for (int it = 0; it < 1500; it++) begin
            k = $urandom_range(0, 29);
            if (k == 0) begin
                rs1 = 7'($urandom); rs0 = 7'($urandom);
                sample_raw(gp == 1, gp == 2, gp == 3, rs1, rs0, "rnd.seg");
            end else if (k == 1) begin
                rl = 3'($urandom_range(0, 7));
                sample_raw(rl[2], rl[1], rl[0], sg(gv / 10), sg(gv % 10), "rnd.lamp");
            end else if (k == 2) begin
                sample_m(gp, $urandom_range(0, 99), "rnd.val");
            end else if (k == 3) begin
                gp = $urandom_range(1, 3);
                gv = $urandom_range(0, 99);
            end else if (k == 4) begin
                idle_cycle();
            end else if (k == 5 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                sample_m(gp, gv, "rnd.legal");
                if (gv > 0) gv--;
                else begin
                    gp = (gp % 3) + 1;
                    gv = times[gp];
                end
            end
        end

        // ---------------- 256-cycle wrap ----------------
        do_reset();
        sample_m(1, RT, "wrap");
        for (int c = 0; c < 256; c++) begin
            legal_cycle_from_red30("wrap");
            if (c == 254) chk("wrap.cycleCount_255", int'(cycleCount), 255);
        end
        chk("wrap.cycleCount_0", int'(cycleCount), 0);
        chk("wrap.errFlags",     int'(errFlags),   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
